// File: rtl/r2sdf_bf_stage_32b.sv
// Radix-2 single-path delay-feedback butterfly stage with twiddle-index tagging.
// Optional macro BF_SCALE_EN: 17-bit butterfly arithmetic with a floor shift right by 1.
module r2sdf_bf_stage_32b #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      A32,
  output logic             out_valid,
  output logic [31:0]      R32,
  output logic             out_diff,
  output logic [IDX_W-1:0] tw_idx
);

  logic [31:0]      dly_q [DEPTH];
  logic [IDX_W:0]   cnt_q;
  logic             primed_q;
  logic             out_valid_q;
  logic [31:0]      r_q;
  logic             diff_q;
  logic [IDX_W-1:0] idx_q;

  logic [31:0]      head;
  logic             phase;
  logic [IDX_W-1:0] k;
  logic [31:0]      push_d;
  logic [31:0]      r_d;
  logic             diff_d;
  logic [IDX_W-1:0] idx_d;
  logic             primed_d;
  logic [IDX_W:0]   cnt_d;

  function automatic logic [15:0] comp_add(input logic [15:0] x, input logic [15:0] y);
`ifdef BF_SCALE_EN
    logic [16:0] s;
    s = {x[15], x} + {y[15], y};
    return s[16:1];
`else
    return x + y;
`endif
  endfunction

  function automatic logic [15:0] comp_sub(input logic [15:0] x, input logic [15:0] y);
`ifdef BF_SCALE_EN
    logic [16:0] s;
    s = {x[15], x} - {y[15], y};
    return s[16:1];
`else
    return x - y;
`endif
  endfunction

  assign head  = dly_q[0];
  assign phase = cnt_q[IDX_W];
  assign k     = cnt_q[IDX_W-1:0];
  // Counter width spans exactly two half-frames, so it wraps at 2*DEPTH on its own.
  assign cnt_d = cnt_q + 1'b1;

  always_comb begin
    push_d   = A32;
    r_d      = head;
    diff_d   = 1'b1;
    idx_d    = k;
    primed_d = primed_q | phase;
    if (phase) begin
      push_d = {comp_sub(head[31:16], A32[31:16]), comp_sub(head[15:0], A32[15:0])};
      r_d    = {comp_add(head[31:16], A32[31:16]), comp_add(head[15:0], A32[15:0])};
      diff_d = 1'b0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      diff_q      <= 1'b0;
      idx_q       <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < DEPTH - 1; i++) dly_q[i] <= dly_q[i+1];
      dly_q[DEPTH-1] <= push_d;
      cnt_q          <= cnt_d;
      primed_q       <= primed_d;
      out_valid_q    <= primed_d;
      r_q            <= r_d;
      diff_q         <= diff_d;
      idx_q          <= idx_d;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign R32       = r_q;
  assign out_diff  = diff_q;
  assign tw_idx    = idx_q;

endmodule

// File: tb/tb_r2sdf_bf_stage_32b.sv
// Bench for r2sdf_bf_stage_32b: DEPTH=4 and DEPTH=32 instances share one stream,
// checked each cycle against a frame-position model plus literal expectations.
module tb_r2sdf_bf_stage_32b;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic [31:0] inData = '0;

  logic        ov4, ov32, d4, d32;
  logic [31:0] r4, r32;
  logic [1:0]  idx4;
  logic [4:0]  idx32;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  int          mCnt [2];
  bit          mPrimed [2];
  logic [31:0] mX [2][32];
  logic [31:0] mD [2][32];
  bit          pValid [2];
  logic [31:0] pR [2];
  bit          pDiff [2];
  int          pIdx [2];

`ifdef BF_SCALE_EN
  localparam logic [31:0] SUMS [4] = '{32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000};
  localparam logic [31:0] DRAIN     = 32'hFFFE_0000;
  localparam logic [31:0] WRAP_SUM  = 32'h4000_C000;
  localparam logic [31:0] WRAP_DIFF = 32'h3FFF_BFFF;
  localparam logic [31:0] ASYNC_SUM = 32'h0011_0000;
`else
  localparam logic [31:0] SUMS [4] = '{32'h0006_0000, 32'h0008_0000, 32'h000A_0000, 32'h000C_0000};
  localparam logic [31:0] DRAIN     = 32'hFFFC_0000;
  localparam logic [31:0] WRAP_SUM  = 32'h8000_8001;
  localparam logic [31:0] WRAP_DIFF = 32'h7FFE_7FFF;
  localparam logic [31:0] ASYNC_SUM = 32'h0022_0000;
`endif

  r2sdf_bf_stage_32b #(.DEPTH(4), .IDX_W(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .A32(inData),
    .out_valid(ov4), .R32(r4), .out_diff(d4), .tw_idx(idx4)
  );

  r2sdf_bf_stage_32b #(.DEPTH(32), .IDX_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(inValid), .A32(inData),
    .out_valid(ov32), .R32(r32), .out_diff(d32), .tw_idx(idx32)
  );

  always #5 clk = ~clk;

  function automatic int depthOf(input int m);
    return (m == 0) ? 4 : 32;
  endfunction

  function automatic logic [15:0] bfComp(input logic [15:0] x, input logic [15:0] y, input bit sub);
    int s;
    s = sub ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
`ifdef BF_SCALE_EN
    s = s >>> 1;
`endif
    return 16'(s);
  endfunction

  function automatic logic [31:0] bfWord(input logic [31:0] older, input logic [31:0] newer, input bit sub);
    return {bfComp(older[31:16], newer[31:16], sub), bfComp(older[15:0], newer[15:0], sub)};
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mCnt[m] = 0;
      mPrimed[m] = 1'b0;
      for (int i = 0; i < 32; i++) begin
        mX[m][i] = '0;
        mD[m][i] = '0;
      end
      pValid[m] = 1'b0;
      pR[m] = '0;
      pDiff[m] = 1'b0;
      pIdx[m] = 0;
    end
  endtask

  // First half of a frame stores inputs and releases last frame's differences;
  // second half pairs each input with its stored partner from the first half.
  task automatic modelAccept(input logic [31:0] a);
    int d, p, j;
    for (int m = 0; m < 2; m++) begin
      d = depthOf(m);
      p = mCnt[m];
      if (p < d) begin
        pR[m] = mD[m][p];
        mX[m][p] = a;
        pDiff[m] = 1'b1;
        pIdx[m] = p;
      end else begin
        j = p - d;
        pR[m] = bfWord(mX[m][j], a, 1'b0);
        mD[m][j] = bfWord(mX[m][j], a, 1'b1);
        pDiff[m] = 1'b0;
        pIdx[m] = 0;
        mPrimed[m] = 1'b1;
      end
      pValid[m] = mPrimed[m];
      mCnt[m] = (p + 1) % (2 * d);
    end
  endtask

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] a);
    @(negedge clk);
    inValid = v;
    inData = a;
    if (v) modelAccept(a);
    else for (int m = 0; m < 2; m++) pValid[m] = 1'b0;
  endtask

  task automatic checkOutput(input string name, input bit v, input logic [31:0] r, input bit df, input int idx);
    @(posedge clk);
    #2;
    checkEq({name, " valid"}, 32'(ov4), 32'(v));
    checkEq({name, " R32"}, r4, r);
    if (v) begin
      checkEq({name, " diff"}, 32'(d4), 32'(df));
      checkEq({name, " idx"}, 32'(idx4), 32'(idx));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    inValid = 1'b0;
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (checkEn) begin
      checkEq("cmp4 valid", 32'(ov4), 32'(pValid[0]));
      checkEq("cmp32 valid", 32'(ov32), 32'(pValid[1]));
      if (pValid[0]) begin
        checkEq("cmp4 R32", r4, pR[0]);
        checkEq("cmp4 diff", 32'(d4), 32'(pDiff[0]));
        checkEq("cmp4 idx", 32'(idx4), 32'(pIdx[0]));
      end
      if (pValid[1]) begin
        checkEq("cmp32 R32", r32, pR[1]);
        checkEq("cmp32 diff", 32'(d32), 32'(pDiff[1]));
        checkEq("cmp32 idx", 32'(idx32), 32'(pIdx[1]));
      end
    end
  end

  initial begin
    modelReset();
    #1 rst = 1'b1;
    #2;
    checkEq("reset valid4", 32'(ov4), 32'h0);
    checkEq("reset R32", r4, 32'h0);
    checkEq("reset diff", 32'(d4), 32'h0);
    checkEq("reset idx", 32'(idx4), 32'h0);
    checkEq("reset valid32", 32'(ov32), 32'h0);
    doReset();
    checkEn = 1'b1;

    // Priming: four samples produce nothing visible
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h1111_2222 * (i + 1));
      checkOutput("prime", 1'b0, 32'h0, 1'b0, 0);
    end

    // Basic butterfly then zero flush
    doReset();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, {16'(i), 16'h0});
      if (i >= 5) checkOutput("basic sum", 1'b1, SUMS[i-5], 1'b0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h0);
      checkOutput("basic drain", 1'b1, DRAIN, 1'b1, i);
    end

    // Same stream with a bubble after every sample
    doReset();
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, (i <= 8) ? {16'(i), 16'h0} : 32'h0);
      if (i == 5) checkOutput("bubble sum", 1'b1, SUMS[0], 1'b0, 0);
      if (i == 10) checkOutput("bubble drain", 1'b1, DRAIN, 1'b1, 1);
      applyStimulus(1'b0, 32'hDEAD_BEEF);
      if (i == 5) checkOutput("bubble hold", 1'b0, SUMS[0], 1'b0, 0);
    end

    // Wrap-around (or scaled) arithmetic corner
    doReset();
    applyStimulus(1'b1, 32'h7FFF_8000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0);
    applyStimulus(1'b1, 32'h0001_0001);
    checkOutput("wrap sum", 1'b1, WRAP_SUM, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0);
    applyStimulus(1'b1, 32'h0);
    checkOutput("wrap diff", 1'b1, WRAP_DIFF, 1'b1, 0);

    // Asynchronous reset in the middle of a DEPTH=32 frame
    doReset();
    for (int n = 0; n < 40; n++) applyStimulus(1'b1, 32'h0003_0005 * (n + 1));
    @(posedge clk);
    #2;
    checkEq("pre-reset valid32", 32'(ov32), 32'h1);
    #1;
    rst = 1'b1;
    inValid = 1'b0;
    modelReset();
    #1;
    checkEq("async valid32", 32'(ov32), 32'h0);
    checkEq("async R32 32", r32, 32'h0);
    checkEq("async valid4", 32'(ov4), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n <= 32; n++) begin
      applyStimulus(1'b1, {16'(n + 1), 16'h0});
      if (n >= 31) begin
        @(posedge clk);
        #2;
        checkEq("post-reset valid32", 32'(ov32), (n == 32) ? 32'h1 : 32'h0);
        if (n == 32) checkEq("post-reset sum32", r32, ASYNC_SUM);
      end
    end

    applyStimulus(1'b0, 32'h0);
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
